telemetria_serial_n: RTL and testbench



---
 rtl/telemetria_serial_n.sv | 189 ++++++++++++++++++
 tb/tb_telemetria_serial_n.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetria_serial_n.sv
// telemetria_serial_n
// Periodic/manual telemetry frame sequencer for the range-finder sensors plus
// a circular receive bank fed by an external 7E1 receiver.
// A frame is NUM_CANAIS groups of DIGITOS ASCII digits, each group followed
// by SEPARADOR, built from a snapshot of medidas taken at frame start.
module telemetria_serial_n #(
   parameter int         NUM_CANAIS  = 3,
   parameter int         DIGITOS     = 3,
   parameter int         PERIODO     = 1_000_000,
   parameter logic [6:0] SEPARADOR   = 7'h23,
   parameter int         NUM_REGS_RX = 3,
   parameter logic [6:0] TERMINADOR  = 7'h0A
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                habilita,
   input  logic                                disparo,
   input  logic [NUM_CANAIS*DIGITOS*4-1:0]     medidas,
   output logic [6:0]                          dados_tx,
   output logic                                partida_tx,
   input  logic                                pronto_tx,
   input  logic [6:0]                          dado_rx,
   input  logic                                pronto_rx,
   output logic [NUM_REGS_RX*7-1:0]            dados_recebidos,
   output logic [$clog2(NUM_REGS_RX)-1:0]      contagem_rx,
   output logic                                rx_completo,
   output logic                                pronto_quadro,
   output logic                                ocupado,
   output logic [3:0]                          db_estado
);

   localparam int MW = NUM_CANAIS*DIGITOS*4;
   localparam int TW = $clog2(PERIODO);
   localparam int CW = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1;
   localparam int DW = $clog2(DIGITOS+1);
   localparam int RW = $clog2(NUM_REGS_RX);

   typedef enum logic [3:0] {
      OCIOSO  = 4'd0,
      CAPTURA = 4'd1,
      CARREGA = 4'd2,
      ESPERA  = 4'd3,
      PROXIMO = 4'd4,
      FIM     = 4'd5
   } estado_t;

   estado_t        estado;
   estado_t        prox;
   logic [TW-1:0]  temporizador;
   logic           tick;
   logic [MW-1:0]  snapshot;
   logic [MW-1:0]  fonte;
   logic [CW-1:0]  canal;
   logic [CW-1:0]  canal_prox;
   logic [DW-1:0]  digito;
   logic [DW-1:0]  digito_prox;
   logic           ultimo;
   logic [3:0]     nibble;
   logic [6:0]     caractere;
   logic [6:0]     registros [NUM_REGS_RX];

   assign tick = habilita && (temporizador == TW'(PERIODO-1));

   // Free-running frame timer, held at zero while disabled
   always_ff @(posedge clock) begin
      if (reset) begin
         temporizador <= '0;
      end else if (!habilita || tick) begin
         temporizador <= '0;
      end else begin
         temporizador <= temporizador + 1'b1;
      end
   end

   // Index of the character to be loaded next; digito==DIGITOS selects the separator
   always_comb begin
      canal_prox  = canal;
      digito_prox = digito;
      ultimo      = 1'b0;
      if (estado == CAPTURA) begin
         canal_prox  = '0;
         digito_prox = '0;
      end else if (digito == DW'(DIGITOS)) begin
         if (canal == CW'(NUM_CANAIS-1)) begin
            ultimo = 1'b1;
         end else begin
            canal_prox  = canal + 1'b1;
            digito_prox = '0;
         end
      end else begin
         digito_prox = digito + 1'b1;
      end
   end

   // Character for the next index; during CAPTURA the snapshot is not loaded yet,
   // so the first character is taken straight from medidas
   always_comb begin
      fonte  = (estado == CAPTURA) ? medidas : snapshot;
      nibble = '0;
      for (int c = 0; c < NUM_CANAIS; c++) begin
         for (int d = 0; d < DIGITOS; d++) begin
            if (canal_prox == CW'(c) && digito_prox == DW'(d)) begin
               nibble = fonte[c*DIGITOS*4 + (DIGITOS-1-d)*4 +: 4];
            end
         end
      end
      caractere = (digito_prox == DW'(DIGITOS)) ? SEPARADOR : {3'b011, nibble};
   end

   // Next-state decode of the frame sequencer
   always_comb begin
      prox = estado;
      case (estado)
         OCIOSO:  if (tick || disparo) prox = CAPTURA;
         CAPTURA: prox = CARREGA;
         CARREGA: prox = ESPERA;
         ESPERA:  if (pronto_tx) prox = PROXIMO;
         PROXIMO: prox = ultimo ? FIM : CARREGA;
         FIM:     prox = OCIOSO;
         default: prox = OCIOSO;
      endcase
   end

   // Sequencer state, indices, snapshot and registered Moore outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= OCIOSO;
         db_estado     <= 4'd0;
         ocupado       <= 1'b0;
         partida_tx    <= 1'b0;
         pronto_quadro <= 1'b0;
         dados_tx      <= '0;
         snapshot      <= '0;
         canal         <= '0;
         digito        <= '0;
      end else begin
         estado        <= prox;
         db_estado     <= prox;
         ocupado       <= (prox != OCIOSO);
         partida_tx    <= (prox == CARREGA);
         pronto_quadro <= (prox == FIM);
         if (estado == CAPTURA) begin
            snapshot <= medidas;
         end
         if (estado == CAPTURA || estado == PROXIMO) begin
            canal  <= canal_prox;
            digito <= digito_prox;
         end
         if (prox == CARREGA) begin
            dados_tx <= caractere;
         end
      end
   end

   // Circular receive bank; the terminator only realigns the write index
   always_ff @(posedge clock) begin
      if (reset) begin
         contagem_rx <= '0;
         rx_completo <= 1'b0;
         for (int i = 0; i < NUM_REGS_RX; i++) begin
            registros[i] <= '0;
         end
      end else begin
         rx_completo <= 1'b0;
         if (pronto_rx) begin
            if (dado_rx == TERMINADOR) begin
               contagem_rx <= '0;
            end else begin
               for (int i = 0; i < NUM_REGS_RX; i++) begin
                  if (contagem_rx == RW'(i)) begin
                     registros[i] <= dado_rx;
                  end
               end
               if (contagem_rx == RW'(NUM_REGS_RX-1)) begin
                  contagem_rx <= '0;
                  rx_completo <= 1'b1;
               end else begin
                  contagem_rx <= contagem_rx + 1'b1;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS_RX; g++) begin : g_banco
      assign dados_recebidos[g*7 +: 7] = registros[g];
   end

endmodule

// File: tb/tb_telemetria_serial_n.sv
// Testbench for telemetria_serial_n: scoreboard of transmitted characters,
// timer cadence on a small second instance, receive bank and reset abort.
module tb_telemetria_serial_n;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   // main instance (3 channels x 3 digits, PERIODO 30)
   logic        habilita, disparo, pronto_tx, pronto_rx;
   logic [35:0] medidas;
   logic [6:0]  dados_tx, dado_rx;
   logic        partida_tx, rx_completo, pronto_quadro, ocupado;
   logic [20:0] dados_recebidos;
   logic [1:0]  contagem_rx;
   logic [3:0]  db_estado;
   // timer instance (1 channel x 1 digit, PERIODO 20)
   logic        habilita2, pronto2, p2_prev;
   logic [6:0]  dados_tx2;
   logic        partida2, rx_completo2, quadro2, ocupado2;
   logic [20:0] dados_recebidos2;
   logic [1:0]  contagem_rx2;
   logic [3:0]  db_estado2;

   telemetria_serial_n #(.PERIODO(30)) u_dut (
      .clock(clk), .reset(rst), .habilita(habilita), .disparo(disparo),
      .medidas(medidas), .dados_tx(dados_tx), .partida_tx(partida_tx),
      .pronto_tx(pronto_tx), .dado_rx(dado_rx), .pronto_rx(pronto_rx),
      .dados_recebidos(dados_recebidos), .contagem_rx(contagem_rx),
      .rx_completo(rx_completo), .pronto_quadro(pronto_quadro),
      .ocupado(ocupado), .db_estado(db_estado));

   telemetria_serial_n #(.NUM_CANAIS(1), .DIGITOS(1), .PERIODO(20)) u_tick (
      .clock(clk), .reset(rst), .habilita(habilita2), .disparo(1'b0),
      .medidas(4'h5), .dados_tx(dados_tx2), .partida_tx(partida2),
      .pronto_tx(pronto2), .dado_rx(7'h00), .pronto_rx(1'b0),
      .dados_recebidos(dados_recebidos2), .contagem_rx(contagem_rx2),
      .rx_completo(rx_completo2), .pronto_quadro(quadro2),
      .ocupado(ocupado2), .db_estado(db_estado2));

   int checks = 0;
   int errors = 0;
   int n_partida = 0;
   int n_quadro = 0;
   int cyc = 0;
   int tx_delay = 10;
   logic [6:0] exp_q[$];
   int capt2[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // expected frame: per channel, digits MS first as {011,nibble}, then '#'
   function automatic void push_frame(input logic [35:0] m);
      for (int c = 0; c < 3; c++) begin
         for (int d = 0; d < 3; d++) begin
            logic [3:0] nib;
            nib = m[c*12 + (2-d)*4 +: 4];
            exp_q.push_back({3'b011, nib});
         end
         exp_q.push_back(7'h23);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // transmitter model + scoreboard pop
   initial begin
      pronto_tx = 1'b0;
      forever begin
         @(negedge clk);
         if (partida_tx) begin
            n_partida++;
            check_val("tx_queue_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_val("tx_char", dados_tx, exp_q.pop_front());
            repeat (tx_delay - 1) @(negedge clk);
            pronto_tx = 1'b1;
            @(negedge clk);
            pronto_tx = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (pronto_quadro) n_quadro++;
   end

   // instant transmitter for the timer instance: done in the cycle after start
   initial begin
      pronto2 = 1'b0;
      p2_prev = 1'b0;
      forever begin
         @(negedge clk);
         pronto2 = p2_prev;
         p2_prev = partida2;
      end
   end

   initial forever begin
      @(negedge clk);
      if (db_estado2 == 4'd1) capt2.push_back(cyc);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, checks %0d", checks);
      $fatal(1);
   end

   task automatic start_frame();
      n_partida = 0;
      @(negedge clk);
      disparo = 1'b1;
      push_frame(medidas);
      @(negedge clk);
      disparo = 1'b0;
   endtask

   task automatic wait_quadro(input int target, input int budget);
      for (int i = 0; i < budget && n_quadro < target; i++) begin
         @(negedge clk);
         #1;
      end
      check_val("quadro_count", n_quadro, target);
   endtask

   task automatic wait_espera(input int n, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_partida == n && db_estado == 4'd3) break;
      end
      check_val("wait_espera_ok", i < budget, 1);
   endtask

   task automatic send_rx(input logic [6:0] ch);
      @(negedge clk);
      dado_rx   = ch;
      pronto_rx = 1'b1;
      @(negedge clk);
      pronto_rx = 1'b0;
   endtask

   initial begin
      int e, nq;
      rst = 1'b1; habilita = 1'b0; disparo = 1'b0; pronto_rx = 1'b0;
      dado_rx = '0; habilita2 = 1'b0;
      medidas = 36'h678045123;
      repeat (3) @(negedge clk);
      check_val("rst_partida", partida_tx, 0);
      check_val("rst_ocupado", ocupado, 0);
      check_val("rst_estado", db_estado, 0);
      check_val("rst_dados_tx", dados_tx, 0);
      check_val("rst_quadro", pronto_quadro, 0);
      check_val("rst_rx", {dados_recebidos, contagem_rx, rx_completo}, 0);
      rst = 1'b0;

      // basic frame and start latency
      start_frame();
      check_val("lat_captura", db_estado, 1);
      @(negedge clk);
      check_val("lat_partida", partida_tx, 1);
      wait_quadro(1, 400);
      check_val("frame1_chars", n_partida, 12);
      check_val("frame1_queue", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      check_val("frame1_idle", {ocupado, db_estado}, 0);

      // timer cadence and re-enable on the small instance
      @(negedge clk);
      capt2.delete();
      e = cyc;
      habilita2 = 1'b1;
      repeat (65) @(negedge clk);
      check_val("tick_n", capt2.size() >= 3, 1);
      check_val("tick_first", capt2[0] - e, 20);
      check_val("tick_period1", capt2[1] - capt2[0], 20);
      check_val("tick_period2", capt2[2] - capt2[1], 20);
      habilita2 = 1'b0;
      repeat (5) @(negedge clk);
      capt2.delete();
      e = cyc;
      habilita2 = 1'b1;
      repeat (25) @(negedge clk);
      check_val("reen_n", capt2.size(), 1);
      check_val("reen_first", capt2[0] - e, 20);
      habilita2 = 1'b0;

      // requests during a frame are dropped
      start_frame();
      wait_espera(3, 100);
      disparo = 1'b1;
      @(negedge clk);
      disparo = 1'b0;
      habilita = 1'b1;
      wait_espera(8, 200);
      habilita = 1'b0;
      wait_quadro(2, 400);
      check_val("drop_chars", n_partida, 12);
      check_val("drop_queue", exp_q.size(), 0);
      repeat (40) @(negedge clk);
      check_val("drop_no_extra", n_quadro, 2);
      check_val("drop_idle", db_estado, 0);

      // snapshot isolation
      start_frame();
      @(negedge clk);
      medidas = 36'h999999999;
      wait_quadro(3, 400);
      check_val("snap_queue", exp_q.size(), 0);
      check_val("snap_chars", n_partida, 12);
      medidas = 36'h678045123;
      repeat (3) @(negedge clk);

      // receive bank
      send_rx(7'h41);
      check_val("rx_a_cnt", contagem_rx, 1);
      check_val("rx_a_reg0", dados_recebidos[6:0], 7'h41);
      check_val("rx_a_done", rx_completo, 0);
      send_rx(7'h42);
      send_rx(7'h43);
      check_val("rx_c_done", rx_completo, 1);
      check_val("rx_c_cnt", contagem_rx, 0);
      send_rx(7'h44);
      check_val("rx_d_bank", dados_recebidos, {7'h43, 7'h42, 7'h44});
      check_val("rx_d_cnt", contagem_rx, 1);
      check_val("rx_d_done", rx_completo, 0);
      send_rx(7'h0A);
      check_val("rx_lf_cnt", contagem_rx, 0);
      check_val("rx_lf_bank", dados_recebidos, {7'h43, 7'h42, 7'h44});
      send_rx(7'h58);
      check_val("rx_x_bank", dados_recebidos, {7'h43, 7'h42, 7'h58});
      check_val("rx_x_cnt", contagem_rx, 1);

      // reset mid-frame
      start_frame();
      wait_espera(5, 200);
      nq = n_quadro;
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_outs", {partida_tx, ocupado, pronto_quadro}, 0);
      check_val("abort_state", db_estado, 0);
      check_val("abort_rx", {dados_recebidos, contagem_rx}, 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (30) @(negedge clk);
      check_val("abort_no_quadro", n_quadro, nq);
      start_frame();
      wait_quadro(nq + 1, 400);
      check_val("restart_queue", exp_q.size(), 0);
      check_val("restart_chars", n_partida, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
